nibble_serial_subtractor: RTL

Multi-cycle WIDTH-bit subtractor computing Diff = A − B − Bin one 4-bit nibble per clock, least-significant nibble first, with the borrow rippling between cycles through a registered borrow bit. It is the inverse-direction companion to the team's combinational ripple adders. It trades latency for area by reusing a single 4-bit ripple-borrow stage, and sits behind a start/busy/done handshake in the datapath.

---
 rtl/nibble_serial_subtractor_pkg.sv | 19 +
 rtl/nibble_serial_subtractor_if.sv | 27 ++
 rtl/nibble_serial_subtractor_sub4.sv | 22 ++
 rtl/nibble_serial_subtractor.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial subtractor.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
package nibble_serial_subtractor_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NIBBLE    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Nibble counter width; a single-nibble operand still gets a 1-bit counter.
    function automatic int cnt_w(input int width);
        return (width / NIBBLE > 1) ? $clog2(width / NIBBLE) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Start/busy/done request bus carrying operands in and the registered result out.
// master drives the request side, slave (the subtractor) drives status and result.
interface nibble_serial_subtractor_if
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;

    modport master (
        output start, A, B, Bin,
        input  busy, done, Diff, Bout, Ovf
    );

    modport slave (
        input  start, A, B, Bin,
        output busy, done, Diff, Bout, Ovf
    );
endinterface

// File: rtl/nibble_serial_subtractor_sub4.sv
// Purpose: combinational 4-bit ripple-borrow subtractor, D = X - Y - Bi, four full-subtractor cells.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
module nibble_sub4 (
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic       Bi,
    output logic [3:0] D,
    output logic       Bo
);
    logic brw;

    always_comb begin
        D   = '0;
        brw = Bi;
        for (int i = 0; i < 4; i++) begin
            D[i] = X[i] ^ Y[i] ^ brw;
            brw  = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & brw);
        end
        Bo = brw;
    end
endmodule

// File: rtl/nibble_serial_subtractor.sv
// Purpose: WIDTH-bit A - B - Bin, one nibble per cycle LSB first; Ovf only when SUB_OVERFLOW_EN is defined.
// Latency: WIDTH/4 RUN cycles after the accepting edge, then a one-cycle done pulse.
// Backpressure: start is taken only while busy = 0 (IDLE or DONE); start during RUN is dropped.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_subtractor_if.slave bus
);
    localparam int            NIB      = WIDTH / NIBBLE;
    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              brw_q, brw_d;
    logic              bout_q, bout_d;

    logic [NIBBLE-1:0]       nib_diff;
    logic                    nib_bo;
    logic [WIDTH+NIBBLE-1:0] res_cat;
    logic                    accept;
    logic                    finish;

    nibble_sub4 u_sub4 (
        .X  (a_q[NIBBLE-1:0]),
        .Y  (b_q[NIBBLE-1:0]),
        .Bi (brw_q),
        .D  (nib_diff),
        .Bo (nib_bo)
    );

    // New difference nibble enters at the top so the LSB nibble ends up at bit 0.
    assign res_cat = {nib_diff, res_q};
    assign accept  = bus.start && (state_q != RUN);
    assign finish  = (state_q == RUN) && (cnt_q == LAST_NIB);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        brw_d   = brw_q;
        bout_d  = bout_q;

        case (state_q)
            RUN: begin
                a_d   = a_q >> NIBBLE;
                b_d   = b_q >> NIBBLE;
                brw_d = nib_bo;
                res_d = res_cat[WIDTH+NIBBLE-1:NIBBLE];
                cnt_d = cnt_q + 1'b1;
                if (finish) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    diff_d  = res_cat[WIDTH+NIBBLE-1:NIBBLE];
                    bout_d  = nib_bo;
                end
            end
            default: state_d = IDLE;
        endcase

        // DONE accepts like IDLE so back-to-back requests lose no cycle.
        if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            a_d     = bus.A;
            b_d     = bus.B;
            brw_d   = bus.Bin;
            res_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SUB_OVERFLOW_EN
    logic a_sgn_q, a_sgn_d, b_sgn_q, b_sgn_d, ovf_q, ovf_d;

    // Operand sign bits are shifted out during RUN, so they are kept aside at accept.
    always_comb begin
        a_sgn_d = a_sgn_q;
        b_sgn_d = b_sgn_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_sgn_d = bus.A[WIDTH-1];
            b_sgn_d = bus.B[WIDTH-1];
        end
        if (finish) begin
            ovf_d = (a_sgn_q ^ b_sgn_q) & (nib_diff[NIBBLE-1] ^ a_sgn_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sgn_q <= 1'b0;
            b_sgn_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_sgn_q <= a_sgn_d;
            b_sgn_q <= b_sgn_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.Ovf = ovf_q;
`else
    assign bus.Ovf = 1'b0;
`endif

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
endmodule
